// File: rtl/edge_scan_pkg.sv
// rtl/edge_scan_pkg.sv - Shared FSM state type and round-robin pick helper for edge_scan_ctrl.
package edge_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_e;

    localparam int MAX_REQ = 32;

    // First set request at or after ptr, wrapping at num; iterating downward
    // lets the lowest rotated offset be the final assignment.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int num, input int ptr);
        int idx;
        rr_pick = ptr;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            idx = ptr + i;
            if (idx >= num) idx = idx - num;
            if (i < num && req[idx[4:0]]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/edge_idx_counter.sv
// rtl/edge_idx_counter.sv - Wrapping COO edge index counter with synchronous clear.
module edge_idx_counter #(
    parameter int COO_EDGES = 6,
    parameter int COO_BW    = $clog2(COO_EDGES)
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              en,
    output logic [COO_BW-1:0] idx,
    output logic              last
);

    localparam logic [COO_BW-1:0] LAST_IDX = COO_BW'(COO_EDGES - 1);

    assign last = (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (clear) begin
            idx <= '0;
        end else if (en) begin
            idx <= last ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/edge_scan_ctrl.sv
// rtl/edge_scan_ctrl.sv - Round-robin arbitrated COO edge scanner.
// Optional abort input is enabled by defining EDGE_SCAN_ABORT_EN.
module edge_scan_ctrl
    import edge_scan_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int COO_EDGES = 6,
    parameter int COO_BW    = $clog2(COO_EDGES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               edge_valid,
    input  logic               edge_ready,
    output logic [COO_BW-1:0]  edge_idx,
    output logic               edge_last,
    output logic               done,
`ifdef EDGE_SCAN_ABORT_EN
    input  logic               abort,
`endif
    output logic               busy
);

    localparam int RR_BW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    scan_state_e        state, state_next;
    logic [NUM_REQ-1:0] grant_next;
    logic [RR_BW-1:0]   winner, winner_next;
    logic [RR_BW-1:0]   rr_ptr, rr_ptr_next;
    logic [RR_BW-1:0]   pick;
    logic [MAX_REQ-1:0] req_ext;
    logic               abort_hit;
    logic               accept;
    logic               cnt_last;

`ifdef EDGE_SCAN_ABORT_EN
    assign abort_hit = (state == SCAN) && abort;
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        req_ext = '0;
        req_ext[NUM_REQ-1:0] = req;
    end

    assign pick       = RR_BW'(rr_pick(req_ext, NUM_REQ, int'(rr_ptr)));
    assign edge_valid = (state == SCAN);
    assign done       = (state == DONE);
    assign busy       = (state != IDLE);
    assign edge_last  = edge_valid && cnt_last;
    // An aborted cycle never counts as a handshake, even with ready high.
    assign accept     = edge_valid && edge_ready && !abort_hit;

    edge_idx_counter #(
        .COO_EDGES(COO_EDGES),
        .COO_BW   (COO_BW)
    ) u_counter (
        .clk  (clk),
        .clear(reset || abort_hit),
        .en   (accept),
        .idx  (edge_idx),
        .last (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            grant  <= '0;
            winner <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_next;
            grant  <= grant_next;
            winner <= winner_next;
            rr_ptr <= rr_ptr_next;
        end
    end

    always_comb begin
        state_next  = state;
        grant_next  = grant;
        winner_next = winner;
        rr_ptr_next = rr_ptr;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_next        = SCAN;
                    winner_next       = pick;
                    grant_next        = '0;
                    grant_next[pick]  = 1'b1;
                end
            end
            SCAN: begin
                if (abort_hit || (accept && cnt_last)) state_next = DONE;
            end
            DONE: begin
                state_next  = IDLE;
                grant_next  = '0;
                rr_ptr_next = (winner == RR_BW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
